// File: rtl/gpio_in_filter_if.sv
// Peripheral register bus between the CPU side and the GPIO input filter.
// data_o is combinational read data for the register selected by addr_i.
interface gpio_in_filter_if;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;

  modport master (
    output we_i,
    output addr_i,
    output data_i,
    input  data_o
  );

  modport slave (
    input  we_i,
    input  addr_i,
    input  data_i,
    output data_o
  );
endinterface

// File: rtl/gpio_in_filter.sv
// Pad input conditioning: 2-flop synchroniser, per-pin debounce, edge detect
// and a small register set with a level interrupt. Bit maps assume NPINS <= 16.
module gpio_in_filter #(
  parameter int NPINS = 16,
  parameter int DB_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  gpio_in_filter_if.slave  bus,
  input  logic [NPINS-1:0] pin_i,
  output logic [NPINS-1:0] pin_o,
  output logic             irq_o
);

  localparam logic [3:0] ADDR_DB_CFG   = 4'h0;
  localparam logic [3:0] ADDR_IRQ_EN   = 4'h4;
  localparam logic [3:0] ADDR_IRQ_PEND = 4'h8;
  localparam logic [3:0] ADDR_STATUS   = 4'hC;

  // Rise lanes live in [15:0], fall lanes in [31:16]; unused lanes stay 0.
  localparam logic [31:0] LANE_MASK = (32'd1 << NPINS) - 32'd1;
  localparam logic [31:0] REG_MASK  = (LANE_MASK << 16) | LANE_MASK;

  logic [NPINS-1:0] s1_reg;
  logic [NPINS-1:0] s2_reg;
  logic [NPINS-1:0] pin_db;
  logic [NPINS-1:0] pin_q_reg;
  logic [DB_W-1:0]  db_cfg_reg;
  logic [31:0]      irq_en_reg;
  logic [31:0]      irq_pend_reg;
  logic [31:0]      irq_pend_next;

  logic [3:0]       addr_lo;
  logic             wr_db_cfg;
  logic             wr_irq_en;
  logic             wr_irq_pend;
  logic [DB_W-1:0]  thr_m1;
  logic [NPINS-1:0] rise;
  logic [NPINS-1:0] fall;
  logic [31:0]      edge_word;
  logic [31:0]      pend_clr;
  logic             unused_addr_bits;

  assign addr_lo          = bus.addr_i[3:0];
  assign unused_addr_bits = ^bus.addr_i[31:4];
  assign wr_db_cfg        = bus.we_i && (addr_lo == ADDR_DB_CFG);
  assign wr_irq_en        = bus.we_i && (addr_lo == ADDR_IRQ_EN);
  assign wr_irq_pend      = bus.we_i && (addr_lo == ADDR_IRQ_PEND);

  // Neff-1 with Neff = max(N,1): N=0 and N=1 both give a single-cycle filter.
  assign thr_m1 = (db_cfg_reg == '0) ? '0 : db_cfg_reg - 1'b1;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_reg <= '0;
      s2_reg <= '0;
    end else begin
      s1_reg <= pin_i;
      s2_reg <= s1_reg;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NPINS; gi++) begin : g_pin
      logic [DB_W-1:0] cnt_reg;
      logic            pin_bit_reg;

      // The >= compare lets a lowered threshold release a counter already past it.
      always_ff @(posedge clk) begin
        if (!rst) begin
          cnt_reg     <= '0;
          pin_bit_reg <= 1'b0;
        end else if (s2_reg[gi] == pin_bit_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg >= thr_m1) begin
          pin_bit_reg <= s2_reg[gi];
          cnt_reg     <= '0;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end

      assign pin_db[gi] = pin_bit_reg;
      assign rise[gi]   = pin_bit_reg & ~pin_q_reg[gi];
      assign fall[gi]   = ~pin_bit_reg & pin_q_reg[gi];
    end
  endgenerate

  assign pin_o     = pin_db;
  assign edge_word = 32'(rise) | (32'(fall) << 16);
  assign pend_clr  = wr_irq_pend ? bus.data_i : 32'd0;

  // A new edge in the same cycle as its W1C clear keeps the bit set.
  assign irq_pend_next = ((irq_pend_reg & ~pend_clr) | (edge_word & irq_en_reg)) & REG_MASK;

  always_ff @(posedge clk) begin
    if (!rst) begin
      pin_q_reg    <= '0;
      db_cfg_reg   <= '0;
      irq_en_reg   <= '0;
      irq_pend_reg <= '0;
    end else begin
      pin_q_reg    <= pin_db;
      irq_pend_reg <= irq_pend_next;
      if (wr_db_cfg) begin
        db_cfg_reg <= bus.data_i[DB_W-1:0];
      end
      if (wr_irq_en) begin
        irq_en_reg <= bus.data_i & REG_MASK;
      end
    end
  end

  assign irq_o = |(irq_pend_reg & irq_en_reg);

  always_comb begin
    bus.data_o = 32'd0;
    if (rst) begin
      case (addr_lo)
        ADDR_DB_CFG:   bus.data_o = 32'(db_cfg_reg);
        ADDR_IRQ_EN:   bus.data_o = irq_en_reg;
        ADDR_IRQ_PEND: bus.data_o = irq_pend_reg;
        ADDR_STATUS:   bus.data_o = (32'(s2_reg) << 16) | 32'(pin_db);
        default:       bus.data_o = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_in_filter.sv
// Directed bench for gpio_in_filter: stimulus pushes expectations into a
// scoreboard queue, a negedge monitor pops and compares them.
module tb_gpio_in_filter;

  typedef struct {
    string       name;
    int          kind;   // 0: data_o, 1: pin_o, 2: irq_o
    logic [31:0] exp;
  } chk_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pin_i;
  logic [15:0] pin_o;
  logic        irq_o;

  chk_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  gpio_in_filter_if bus ();

  gpio_in_filter #(
    .NPINS(16),
    .DB_W (8)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .pin_i(pin_i),
    .pin_o(pin_o),
    .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin : monitor
    chk_t        c;
    logic [31:0] act;
    while (sb_q.size() > 0) begin
      c = sb_q.pop_front();
      case (c.kind)
        0:       act = bus.data_o;
        1:       act = {16'h0, pin_o};
        default: act = {31'h0, irq_o};
      endcase
      n_tests++;
      if (act !== c.exp) begin
        n_fail++;
        $display("[TB] FAIL %s: got %08h, expected %08h", c.name, act, c.exp);
      end else begin
        $display("[TB] ok   %s: %08h", c.name, act);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic push(input string name, input int kind, input logic [31:0] exp);
    chk_t c;
    c.name = name;
    c.kind = kind;
    c.exp  = exp;
    sb_q.push_back(c);
  endtask

  task automatic chk_pin(input string name, input logic [15:0] exp);
    push(name, 1, {16'h0, exp});
  endtask

  task automatic chk_irq(input string name, input logic exp);
    push(name, 2, {31'h0, exp});
  endtask

  task automatic rd_now(input string name, input logic [3:0] a, input logic [31:0] exp);
    bus.addr_i = {28'h0, a};
    push(name, 0, exp);
  endtask

  task automatic rd(input string name, input logic [3:0] a, input logic [31:0] exp);
    rd_now(name, a, exp);
    step();
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    bus.we_i   = 1'b1;
    bus.addr_i = {28'h0, a};
    bus.data_i = d;
    step();
    bus.we_i   = 1'b0;
  endtask

  initial begin
    rst        = 1'b0;
    pin_i      = 16'hFFFF;
    bus.we_i   = 1'b0;
    bus.addr_i = 32'h0;
    bus.data_i = 32'h0;

    // Reset held with all pads high
    steps(3);
    chk_pin("rst_pin", 16'h0000);
    chk_irq("rst_irq", 1'b0);
    step();
    rd("rst_db_cfg", 4'h0, 32'h0);
    rd("rst_irq_en", 4'h4, 32'h0);
    rd("rst_pend", 4'h8, 32'h0);
    rd("rst_status", 4'hC, 32'h0);

    // Release with N=0: s2 after k+1, pin_o after k+2
    rst = 1'b1;
    step();
    chk_pin("n0_pin_k", 16'h0000);
    step();
    chk_pin("n0_pin_k1", 16'h0000);
    rd("n0_status_k1", 4'hC, 32'hFFFF_0000);
    chk_pin("n0_pin_k2", 16'hFFFF);
    chk_irq("n0_irq", 1'b0);
    step();
    pin_i = 16'h0000;
    steps(5);
    chk_pin("settle_low", 16'h0000);
    step();

    // Debounce latency with N=5
    wr(4'h0, 32'hFFFF_FF05);
    rd("db_cfg_5", 4'h0, 32'h0000_0005);
    pin_i = 16'h0008;
    step();
    for (int j = 1; j <= 5; j++) begin
      step();
      chk_pin($sformatf("db5_pin_k%0d", j), 16'h0000);
      if (j == 1) rd_now("db5_status_k1", 4'hC, 32'h0008_0000);
    end
    step();
    chk_pin("db5_pin_k6", 16'h0008);
    step();

    // Glitch rejection: 4-cycle pulse on pin 7 with its edges enabled
    wr(4'h4, 32'h0080_0080);
    pin_i = 16'h0088;
    for (int j = 0; j < 14; j++) begin
      if (j == 4) pin_i = 16'h0008;
      if (j == 3 || j == 7 || j == 13) chk_pin($sformatf("glitch_pin_%0d", j), 16'h0008);
      step();
    end
    chk_irq("glitch_irq", 1'b0);
    rd("glitch_pend", 4'h8, 32'h0);

    // Edge interrupts on pin 0 with N=2
    wr(4'h0, 32'h2);
    wr(4'h4, 32'h0001_0001);
    rd("irq_en_rb", 4'h4, 32'h0001_0001);
    pin_i = 16'h0009;
    steps(8);
    pin_i = 16'h0008;
    steps(8);
    chk_irq("edge_irq", 1'b1);
    rd("edge_pend", 4'h8, 32'h0001_0001);
    wr(4'h8, 32'h0000_0001);
    chk_irq("w1c_irq", 1'b1);
    rd("w1c_pend", 4'h8, 32'h0001_0000);
    wr(4'h8, 32'h0000_0000);
    rd("w0_pend", 4'h8, 32'h0001_0000);
    wr(4'h4, 32'h0);
    chk_irq("en_off_irq", 1'b0);
    rd("en_off_pend", 4'h8, 32'h0001_0000);
    wr(4'h8, 32'h0001_0000);
    rd("clr_all_pend", 4'h8, 32'h0);

    // Set/clear collision on pin 2 (N=2: pending sets at edge k+4)
    wr(4'h4, 32'h0000_0004);
    pin_i = 16'h000C;
    steps(4);
    bus.we_i   = 1'b1;
    bus.addr_i = 32'h8;
    bus.data_i = 32'h0000_0004;
    push("coll_pend_pre", 0, 32'h0);
    step();
    bus.we_i = 1'b0;
    chk_irq("coll_irq", 1'b1);
    rd("coll_pend", 4'h8, 32'h0000_0004);

    // Threshold lowered mid-count
    wr(4'h0, 32'd200);
    rd("db_cfg_200", 4'h0, 32'd200);
    pin_i = 16'h000E;
    steps(100);
    chk_pin("thr_hold", 16'h000C);
    bus.we_i   = 1'b1;
    bus.addr_i = 32'h0;
    bus.data_i = 32'd10;
    step();
    bus.we_i = 1'b0;
    chk_pin("thr_write_edge", 16'h000C);
    step();
    chk_pin("thr_next_edge", 16'h000E);
    step();

    // Unmapped and read-only offsets ignore writes
    wr(4'h1, 32'hFFFF_FFFF);
    rd("unmapped_rd", 4'h1, 32'h0);
    rd("db_cfg_kept", 4'h0, 32'd10);
    wr(4'hC, 32'h0);
    rd("status_ro", 4'hC, 32'h000E_000E);

    // Reset asserted with a pending interrupt
    chk_irq("pre_rst_irq", 1'b1);
    step();
    rst = 1'b0;
    step();
    chk_pin("mid_rst_pin", 16'h0000);
    chk_irq("mid_rst_irq", 1'b0);
    rd("mid_rst_data", 4'h8, 32'h0);
    rst = 1'b1;
    rd("post_rst_pend", 4'h8, 32'h0);
    rd("post_rst_en", 4'h4, 32'h0);
    chk_irq("post_rst_irq", 1'b0);
    steps(3);

    if (sb_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL scoreboard_drain: got %0d left, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
